muldiv_sequencer: RTL and testbench

//  Multi-cycle RV32M multiply/divide unit beside the single-cycle ALU. Decode steers funct7=0000001
//  R-type ops here. The block holds the CPU with stall until the result is ready.

---
 rtl/muldiv_pkg.sv | 36 +++
 rtl/muldiv_step.sv | 36 +++
 rtl/muldiv_sequencer.sv | 156 +++++++++++++++
 tb/tb_muldiv_sequencer.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and helpers for the RV32M multiply/divide sequencer.
// Provides the FSM state enum, funct3 encodings and operand signedness decode.
package muldiv_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        CALC,
        FIX,
        DONE
    } muldiv_state_t;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    function automatic logic is_signed_a(input logic [2:0] f);
        return (f == F3_MUL) || (f == F3_MULH) || (f == F3_MULHSU) ||
               (f == F3_DIV) || (f == F3_REM);
    endfunction

    function automatic logic is_signed_b(input logic [2:0] f);
        return (f == F3_MUL) || (f == F3_MULH) ||
               (f == F3_DIV) || (f == F3_REM);
    endfunction

    function automatic logic is_div(input logic [2:0] f);
        return f[2];
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shift-add multiplier / restoring divider (combinational).
// Ports: is_div selects divide; hi/lo accumulator pair and opnd in, hi_nxt/lo_nxt out.
module muldiv_step #(
    parameter int XLEN = 32
) (
    input  logic            is_div,
    input  logic [XLEN-1:0] hi,
    input  logic [XLEN-1:0] lo,
    input  logic [XLEN-1:0] opnd,
    output logic [XLEN-1:0] hi_nxt,
    output logic [XLEN-1:0] lo_nxt
);

    logic [XLEN:0]   sum;
    logic [XLEN:0]   shifted;
    logic [XLEN-1:0] sub;
    logic            ok;

    always_comb begin
        // multiply: lo holds the multiplier, opnd the multiplicand
        sum     = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
        // divide: lo holds the dividend shifting out and quotient shifting in
        shifted = {hi, lo[XLEN-1]};
        ok      = shifted >= {1'b0, opnd};
        // partial remainder stays below the divisor, so XLEN bits suffice
        sub     = shifted[XLEN-1:0] - opnd;
        if (is_div) begin
            hi_nxt = ok ? sub : shifted[XLEN-1:0];
            lo_nxt = {lo[XLEN-2:0], ok};
        end else begin
            hi_nxt = sum[XLEN:1];
            lo_nxt = {sum[0], lo[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle RV32M multiply/divide unit; holds the CPU via stall until done.
// Ports: clk, rst_n, start, flush, fun3, operand_a, operand_b -> stall, busy, done, result.
// Optional MULDIV_EARLY_OUT_EN: skip CALC when an operand makes the answer trivial.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            flush,
    input  logic [2:0]      fun3,
    input  logic [XLEN-1:0] operand_a,
    input  logic [XLEN-1:0] operand_b,
    output logic            stall,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN);

    muldiv_state_t state, state_nxt;

    logic [CW-1:0]     cnt;
    logic [2:0]        f3;
    logic              sgn_a, sgn_b;
    logic [XLEN-1:0]   a_lat, b_lat;
    logic [XLEN-1:0]   hi, lo, opnd;
    logic [XLEN-1:0]   hi_nxt, lo_nxt;
    logic [XLEN-1:0]   result_q;
    logic              busy_q;
    logic              skip;

    logic              div_zero, mul_zero, neg;
    logic [2*XLEN-1:0] prod, prod_s;
    logic [XLEN-1:0]   quo, rem, fix_val;

    muldiv_step #(
        .XLEN(XLEN)
    ) u_step (
        .is_div(is_div(f3)),
        .hi    (hi),
        .lo    (lo),
        .opnd  (opnd),
        .hi_nxt(hi_nxt),
        .lo_nxt(lo_nxt)
    );

`ifdef MULDIV_EARLY_OUT_EN
    assign skip = (b_lat == '0) | (~is_div(f3) & (a_lat == '0));
`else
    assign skip = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (start) state_nxt = PREP;
            PREP: state_nxt = skip ? FIX : CALC;
            CALC: if (cnt == CW'(XLEN - 1)) state_nxt = FIX;
            FIX:  state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (flush) state_nxt = IDLE;
    end

    always_comb begin
        div_zero = (b_lat == '0);
        mul_zero = (a_lat == '0) | div_zero;
        neg      = sgn_a ^ sgn_b;
        prod     = {hi, lo};
        prod_s   = neg ? -prod : prod;
        // x/0 yields all ones with no sign fix; remainder is the dividend
        quo      = div_zero ? '1 : (neg ? -lo : lo);
        rem      = div_zero ? a_lat : (sgn_a ? -hi : hi);
        fix_val  = '0;
        unique case (f3)
            F3_MUL:
                fix_val = mul_zero ? '0 : prod_s[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU:
                fix_val = mul_zero ? '0 : prod_s[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:
                fix_val = quo;
            F3_REM, F3_REMU:
                fix_val = rem;
            default:
                fix_val = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            f3       <= '0;
            sgn_a    <= 1'b0;
            sgn_b    <= 1'b0;
            a_lat    <= '0;
            b_lat    <= '0;
            hi       <= '0;
            lo       <= '0;
            opnd     <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
        end else begin
            busy_q <= (state_nxt == PREP) || (state_nxt == CALC) ||
                      (state_nxt == FIX);
            unique case (state)
                IDLE: begin
                    if (start && !flush) begin
                        f3    <= fun3;
                        a_lat <= operand_a;
                        b_lat <= operand_b;
                        sgn_a <= is_signed_a(fun3) & operand_a[XLEN-1];
                        sgn_b <= is_signed_b(fun3) & operand_b[XLEN-1];
                    end
                end
                PREP: begin
                    hi   <= '0;
                    lo   <= sgn_a ? -a_lat : a_lat;
                    opnd <= sgn_b ? -b_lat : b_lat;
                    cnt  <= '0;
                end
                CALC: begin
                    hi  <= hi_nxt;
                    lo  <= lo_nxt;
                    cnt <= cnt + CW'(1);
                end
                FIX: begin
                    if (!flush) result_q <= fix_val;
                end
                DONE: begin
                end
                default: begin
                end
            endcase
        end
    end

    assign stall  = (start && state == IDLE) ||
                    (state != IDLE && state != DONE);
    assign busy   = busy_q;
    assign done   = (state == DONE);
    assign result = result_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed self-checking bench for muldiv_sequencer.
// Covers reset, all op classes, divide corner cases, flush/reset aborts and handshake.
module tb_muldiv_sequencer;
    import muldiv_pkg::*;

`ifdef MULDIV_EARLY_OUT_EN
    localparam int EO_LAT = 3;
`else
    localparam int EO_LAT = 35;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        flush;
    logic [2:0]  fun3;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic        stall;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    muldiv_sequencer #(
        .XLEN(32)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .flush    (flush),
        .fun3     (fun3),
        .operand_a(operand_a),
        .operand_b(operand_b),
        .stall    (stall),
        .busy     (busy),
        .done     (done),
        .result   (result)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at posedge+1 with the DUT idle; returns at posedge+1 idle.
    task automatic do_op(input string tag, input logic [2:0] f,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int lat);
        int cyc;
        bit hold_ok;
        fun3      = f;
        operand_a = a;
        operand_b = b;
        start     = 1'b1;
        @(negedge clk);
        check({tag, " stall0"}, 32'(stall), 32'd1);
        @(posedge clk);
        #1;
        start     = 1'b0;
        operand_a = 32'hDEAD_BEEF;
        operand_b = 32'h0000_0003;
        cyc       = 1;
        hold_ok   = 1'b1;
        while (cyc < 100) begin
            @(negedge clk);
            if (done === 1'b1) break;
            if (!(busy === 1'b1 && stall === 1'b1)) hold_ok = 1'b0;
            cyc++;
        end
        check({tag, " latency"}, 32'(cyc), 32'(lat));
        check({tag, " result"}, result, exp);
        check({tag, " hold"}, 32'(hold_ok), 32'd1);
        check({tag, " stall_done"}, 32'(stall), 32'd0);
        @(negedge clk);
        check({tag, " done_pulse"}, 32'({done, busy}), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        logic [31:0] r;
        rst_n     = 1'b0;
        start     = 1'b0;
        flush     = 1'b0;
        fun3      = 3'b000;
        operand_a = '0;
        operand_b = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst result", result, 32'd0);
        check("rst stall", 32'(stall), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst outs", {29'd0, busy, done, stall}, 32'd0);
        @(posedge clk);
        #1;

        do_op("mul", F3_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 35);
        do_op("mulh", F3_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 35);
        do_op("mulhu", F3_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
              32'hFFFF_FFFE, 35);
        do_op("mulhsu", F3_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
              32'hFFFF_FFFF, 35);
        do_op("mul2", F3_MUL, 32'h1234_5678, 32'h10, 32'h2345_6780, 35);
        do_op("mul0", F3_MUL, 32'h0, 32'd5, 32'h0, EO_LAT);
        do_op("div", F3_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 35);
        do_op("rem", F3_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 35);
        do_op("divu0", F3_DIVU, 32'd100, 32'd0, 32'hFFFF_FFFF, EO_LAT);
        do_op("rem0", F3_REM, 32'd100, 32'd0, 32'd100, EO_LAT);
        do_op("divneg0", F3_DIV, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF,
              EO_LAT);
        do_op("remneg0", F3_REM, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB,
              EO_LAT);
        do_op("divovf", F3_DIV, 32'h8000_0000, 32'hFFFF_FFFF,
              32'h8000_0000, 35);
        do_op("removf", F3_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 35);
        do_op("divu", F3_DIVU, 32'd1000, 32'd7, 32'd142, 35);

        // flush in CALC iteration 10; flush beats a fresh start
        fun3      = F3_DIV;
        operand_a = 32'd1000;
        operand_b = 32'd3;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (11) @(posedge clk);
        #1;
        flush = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check("flush idle", {30'd0, busy, stall}, 32'd0);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done === 1'b1) n++;
        end
        check("flush nodone", 32'(n), 32'd0);
        check("flush result", result, 32'd142);
        @(posedge clk);
        #1;
        do_op("after_flush", F3_REMU, 32'd1000, 32'd3, 32'd1, 35);

        // asynchronous reset in the middle of CALC
        fun3      = F3_MULHU;
        operand_a = 32'hFFFF_FFFF;
        operand_b = 32'h2;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("arst outs", {29'd0, busy, done, stall}, 32'd0);
        check("arst result", result, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done === 1'b1) n++;
        end
        check("arst nodone", 32'(n), 32'd0);
        @(posedge clk);
        #1;
        do_op("after_rst", F3_MULHU, 32'hFFFF_FFFF, 32'h2, 32'h1, 35);

        // start held through the whole op: a single accepted op
        fun3      = F3_MULHU;
        operand_a = 32'h0001_0000;
        operand_b = 32'h0001_0000;
        start     = 1'b1;
        n = 0;
        r = '0;
        for (int i = 0; i < 36; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                n++;
                r = result;
            end
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        check("hold ndone", 32'(n), 32'd1);
        check("hold result", r, 32'h1);
        @(negedge clk);
        check("hold idle", 32'(busy), 32'd0);
        @(posedge clk);
        #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
